// File: rtl/spi_burst_master.sv
// SPI master running address-plus-burst read/write transactions in any SPI mode.
// Byte-level write handshake on the host side, streaming read bytes out.
module spi_burst_master #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = 5
) (
    input  logic             Mclk,
    input  logic             nReset,
    input  logic             start,
    input  logic             rw,
    input  logic [1:0]       mode,
    input  logic [6:0]       addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_clk,
    output logic             spi_cs,
    output logic             spi_mosi,
    input  logic             spi_miso
);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, FETCH, HOLD} state_t;
    state_t state, state_nx;

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       edge_cnt;   // SCLK edges already issued in the current byte
    logic [7:0]       tx_sh, rx_sh;
    logic [LEN_W-1:0] remain;     // data bytes not yet fetched
    logic             rw_q, cpol_q, cpha_q, addr_phase, rx_pend;
    logic             tick, lead, last_edge, sample, fetch_go;
    logic [LEN_W-1:0] len_clamp;

    assign len_clamp = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign lead      = ~edge_cnt[0];
    assign last_edge = (edge_cnt == 4'd15);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    assign sample    = lead ^ cpha_q;
    assign fetch_go  = (state == FETCH) && (rw_q || tx_valid);
    assign tx_ready  = (state == FETCH) && !rw_q && tx_valid;

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = SETUP;
            SETUP: if (tick) state_nx = SHIFT;
            SHIFT: if (tick && last_edge) state_nx = (remain != '0) ? FETCH : HOLD;
            FETCH: if (fetch_go) state_nx = SHIFT;
            HOLD:  if (tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            div_cnt    <= '0;
            edge_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            remain     <= '0;
            rw_q       <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            addr_phase <= 1'b0;
            rx_pend    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_clk    <= 1'b0;
            spi_cs     <= 1'b1;
            spi_mosi   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if ((state == SETUP || state == SHIFT || state == HOLD) && !tick)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;
            // received byte is published one cycle after its last sampling edge
            if (rx_pend) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                rx_pend  <= 1'b0;
            end
            unique case (state)
                IDLE: if (start) begin
                    rw_q       <= rw;
                    cpol_q     <= mode[1];
                    cpha_q     <= mode[0];
                    remain     <= len_clamp;
                    busy       <= 1'b1;
                    spi_cs     <= 1'b0;
                    spi_clk    <= mode[1];
                    edge_cnt   <= '0;
                    addr_phase <= 1'b1;
                    if (mode[0]) begin
                        tx_sh    <= {rw, addr};
                        spi_mosi <= 1'b0;
                    end else begin
                        tx_sh    <= {addr, 1'b0};
                        spi_mosi <= rw;
                    end
                end
                SHIFT: if (tick) begin
                    spi_clk  <= ~spi_clk;
                    edge_cnt <= edge_cnt + 4'd1;
                    if (sample) begin
                        rx_sh <= {rx_sh[6:0], spi_miso};
                        if (edge_cnt[3:1] == 3'b111 && rw_q && !addr_phase)
                            rx_pend <= 1'b1;
                    end else begin
                        spi_mosi <= tx_sh[7];
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                    end
                    if (last_edge) addr_phase <= 1'b0;
                end
                FETCH: if (fetch_go) begin
                    remain <= remain - 1'b1;
                    if (rw_q) begin
                        tx_sh    <= '0;
                        spi_mosi <= 1'b0;
                    end else if (cpha_q) begin
                        tx_sh <= tx_data;
                    end else begin
                        // CPHA=0 needs the MSB on the wire before the first leading edge
                        tx_sh    <= {tx_data[6:0], 1'b0};
                        spi_mosi <= tx_data[7];
                    end
                end
                HOLD: if (tick) begin
                    spi_cs <= 1'b1;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
